// File: rtl/led_blink_bank.sv
// Bank of independent runtime-programmable LED drivers: OFF / ON / BLINK / PULSE per channel,
// each with its own half-period divisor, synchronised enable and a registered tick strobe.
module led_blink_bank #(
    parameter int N_CH            = 4,
    parameter int CLK_FREQ_HZ     = 50_000_000,
    parameter int DIV_W           = 26,
    parameter int RST_HALF_PERIOD = CLK_FREQ_HZ / 2,
    localparam int CH_W           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [DIV_W-1:0]  cfg_half_period,
    output logic [N_CH-1:0]   led,
    output logic [N_CH-1:0]   tick
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_PULSE = 2'b11
    } mode_e;

    localparam logic [DIV_W-1:0] RST_HP = DIV_W'(RST_HALF_PERIOD);
    localparam logic [DIV_W-1:0] ONE    = DIV_W'(1);

    logic [N_CH-1:0] en_meta_q;
    logic [N_CH-1:0] en_s_q;

    // Two-flop synchroniser for the asynchronous board switches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_meta_q <= '0;
            en_s_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge value,
            // so the two stages really form a 2-cycle pipeline.
            en_meta_q <= en;
            en_s_q    <= en_meta_q;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        mode_e            mode_q, mode_d;
        logic [DIV_W-1:0] hp_q, hp_d;
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [DIV_W-1:0] hp_eff;
        logic             led_q, led_d;
        logic             tick_q, tick_d;
        logic             sel;
        logic             term;

        // Indices >= N_CH never match any channel, so such writes are dropped.
        assign sel    = cfg_we && (cfg_ch == CH_W'(i));
        assign hp_eff = (hp_q == '0) ? ONE : hp_q;
        assign term   = (cnt_q == hp_eff - ONE);

        always_comb begin
            // NOTE: every output gets a default first so no path leaves a value
            // unassigned, which would otherwise infer a latch.
            mode_d = mode_q;
            hp_d   = hp_q;
            cnt_d  = cnt_q;
            led_d  = led_q;
            tick_d = 1'b0;

            if (sel) begin
                mode_d = mode_e'(cfg_mode);
                hp_d   = cfg_half_period;
                cnt_d  = '0;
                led_d  = (cfg_mode == MODE_ON);
            end else if (!en_s_q[i]) begin
                cnt_d = '0;
                led_d = 1'b0;
            end else begin
                unique case (mode_q)
                    MODE_OFF: begin
                        cnt_d = '0;
                        led_d = 1'b0;
                    end
                    MODE_ON: begin
                        cnt_d = '0;
                        led_d = 1'b1;
                    end
                    MODE_BLINK, MODE_PULSE: begin
                        if (term) begin
                            cnt_d  = '0;
                            tick_d = 1'b1;
                            led_d  = (mode_q == MODE_BLINK) ? ~led_q : 1'b1;
                        end else begin
                            cnt_d = cnt_q + ONE;
                            led_d = (mode_q == MODE_BLINK) ? led_q : 1'b0;
                        end
                    end
                    default: begin
                        cnt_d = '0;
                        led_d = 1'b0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mode_q <= MODE_BLINK;
                hp_q   <= RST_HP;
                cnt_q  <= '0;
                led_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                mode_q <= mode_d;
                hp_q   <= hp_d;
                cnt_q  <= cnt_d;
                led_q  <= led_d;
                tick_q <= tick_d;
            end
        end

        assign led[i]  = led_q;
        assign tick[i] = tick_q;
    end

endmodule

// File: tb/tb_led_blink_bank.sv
// Bench for led_blink_bank: directed scenarios plus random traffic, checked every cycle
// against an elapsed-cycle reference model. A 3-channel copy shares the bus so cfg_ch=3 is invalid there.
module tb_led_blink_bank;

    localparam int OFF = 0, ON = 1, BLINK = 2, PULSE = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  en;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [1:0]  cfg_mode;
    logic [25:0] cfg_half_period;
    logic [3:0]  led4, tick4;
    logic [2:0]  led3, tick3;

    int checks = 0;
    int errors = 0;

    // Reference model: each channel counts edges since its last restart.
    int         m_mode [4];
    int         m_hp   [4];
    int         m_run  [4];
    logic [3:0] m_led, m_tick, m_en_d1, m_en_s;

    always #5 clk = ~clk;

    led_blink_bank #(.N_CH(4), .RST_HALF_PERIOD(8)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_half_period(cfg_half_period), .led(led4), .tick(tick4)
    );

    led_blink_bank #(.N_CH(3), .RST_HALF_PERIOD(8)) u_dut3 (
        .clk(clk), .rst(rst), .en(en[2:0]), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_half_period(cfg_half_period), .led(led3), .tick(tick3)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_mode[i] = BLINK;
            m_hp[i]   = 8;
            m_run[i]  = 0;
        end
        m_led   = '0;
        m_tick  = '0;
        m_en_d1 = '0;
        m_en_s  = '0;
    endtask

    task automatic model_edge();
        int hpe;
        for (int i = 0; i < 4; i++) begin
            if (cfg_we && int'(cfg_ch) == i) begin
                m_mode[i] = int'(cfg_mode);
                m_hp[i]   = int'(cfg_half_period);
                m_run[i]  = 0;
                m_led[i]  = (m_mode[i] == ON);
                m_tick[i] = 1'b0;
            end else if (!m_en_s[i] || m_mode[i] == OFF || m_mode[i] == ON) begin
                m_run[i]  = 0;
                m_led[i]  = m_en_s[i] && (m_mode[i] == ON);
                m_tick[i] = 1'b0;
            end else begin
                hpe       = (m_hp[i] == 0) ? 1 : m_hp[i];
                m_run[i]  = m_run[i] + 1;
                m_tick[i] = (m_run[i] % hpe) == 0;
                m_led[i]  = (m_mode[i] == BLINK) ? (((m_run[i] / hpe) % 2) == 1) : m_tick[i];
            end
        end
        m_en_s  = m_en_d1;
        m_en_d1 = en;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check("led4", led4, m_led);
        check("tick4", tick4, m_tick);
        check("led3", {1'b0, led3}, {1'b0, m_led[2:0]});
        check("tick3", {1'b0, tick3}, {1'b0, m_tick[2:0]});
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic write(input int ch, input int mode, input int hp);
        cfg_we          = 1'b1;
        cfg_ch          = 2'(ch);
        cfg_mode        = 2'(mode);
        cfg_half_period = 26'(hp);
        cycle();
        cfg_we = 1'b0;
    endtask

    initial begin
        int  b;
        bit  found;
        rst             = 1'b1;
        en              = 4'hF;
        cfg_we          = 1'b0;
        cfg_ch          = '0;
        cfg_mode        = '0;
        cfg_half_period = '0;
        model_reset();

        #3;
        check("reset_led", led4, 4'h0);
        check("reset_tick", tick4, 4'h0);

        // Release and watch the first rise: sync takes 2 edges, then 8 counting edges.
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycles(9);
        check("pre_first_rise", led4, 4'h0);
        cycle();
        check("first_rise", led4, 4'hF);
        check("first_tick", tick4, 4'hF);
        cycles(4);

        // Asynchronous reset between edges.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_led4", led4, 4'h0);
        check("async_rst_tick4", tick4, 4'h0);
        check("async_rst_led3", {1'b0, led3}, 4'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        en  = 4'b0010;
        cycles(12);

        // Blink period 10 on ch1 only.
        write(1, BLINK, 5);
        cycles(25);

        // hp=0 on ch2 acts as hp=1.
        en = 4'b0110;
        cycles(3);
        write(2, BLINK, 0);
        cycles(6);
        check("hp0_tick2", {3'b0, tick4[2]}, 4'b0001);

        // Write to ch1 exactly at its terminal count.
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (m_run[1] % 5 == 4) found = 1'b1;
            else cycle();
        end
        checks++;
        assert (found)
        else begin
            errors++;
            $error("FAIL term_count_wait: observed=timeout expected=cnt==4");
        end
        write(1, BLINK, 5);
        check("term_no_toggle", {3'b0, led4[1]}, 4'b0000);
        cycles(12);

        // Mode walk on ch0; ch3 keeps its reset BLINK behaviour.
        en = 4'b1111;
        cycles(3);
        write(0, ON, 3);
        check("on_led0", {3'b0, led4[0]}, 4'b0001);
        cycles(3);
        write(0, OFF, 3);
        check("off_led0", {3'b0, led4[0]}, 4'b0000);
        cycles(3);
        write(0, PULSE, 4);
        cycles(16);

        // Enable drop mid-count on ch3, then re-enable.
        cycles(3);
        en[3] = 1'b0;
        cycles(3);
        check("en_drop_led3", {3'b0, led4[3]}, 4'b0000);
        cycles(4);
        en[3] = 1'b1;
        cycles(20);

        // cfg_ch=3 is valid for the 4-channel copy and invalid for the 3-channel copy.
        write(3, ON, 2);
        cycles(4);
        write(3, PULSE, 3);
        cycles(10);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(7) == 0) begin
                write(int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(6)));
            end else begin
                if ($urandom_range(15) == 0) begin
                    b     = int'($urandom_range(3));
                    en[b] = ~en[b];
                end
                cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
